// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC register, combinational imem read and a small tagged fetch buffer
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_addr / imem_rdata      instruction memory address (= PC) and same-cycle read data
//   redirect_valid/redirect_pc  execute redirect; a misaligned target flushes and halts fetch
//   dec_valid/dec_ready         decode handshake on the buffer head
//   dec_instr/dec_pc            head instruction word and its PC
//   misalign_err                sticky flag set by a misaligned redirect target
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        misalign_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic          err_q, err_d;
    logic [63:0]   fifo_q [FIFO_DEPTH];
    logic [63:0]   fifo_d [FIFO_DEPTH];
    logic          run, redir, mis, pop, push;

    assign imem_addr    = pc_q;
    assign dec_valid    = cnt_q != '0;
    assign dec_pc       = fifo_q[rp_q][63:32];
    assign dec_instr    = fifo_q[rp_q][31:0];
    assign misalign_err = err_q;

    always_comb begin
        run   = state_q == RUN;
        redir = run & redirect_valid;
        mis   = redir & (redirect_pc[1:0] != 2'b00);
        pop   = dec_valid & dec_ready;
        // Redirect outranks push; a pop still frees a slot for this cycle's push.
        push  = run & ~redirect_valid & ((cnt_q < DEPTH_C) | pop);
        pc_d    = (redir & ~mis) ? redirect_pc : push ? pc_q + 32'd4 : pc_q;
        cnt_d   = redir ? '0 : cnt_q + CW'(push) - CW'(pop);
        wp_d    = redir ? '0 : push ? wp_q + AW'(1) : wp_q;
        rp_d    = redir ? '0 : pop ? rp_q + AW'(1) : rp_q;
        state_d = mis ? HALT : state_q;
        err_d   = err_q | mis;
        fifo_d  = fifo_q;
        if (push) fifo_d[wp_q] = {pc_q, imem_rdata};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            err_q   <= err_d;
        end
    end

    // Buffer payload needs no reset: it is only visible while dec_valid is high.
    always_ff @(posedge clk) fifo_q <= fifo_d;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based reference model and literal checks
module tb_fetch_unit;
    logic        clk, rst_n, redirect_valid, dec_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, dec_instr, dec_pc;
    logic        dec_valid, misalign_err;
    logic        rst2_n, dec_ready2, dec_valid2, err2;
    logic [31:0] imem2_addr, imem2_rdata, dec_instr2, dec_pc2;
    int checks = 0, errors = 0;

    logic [31:0] m_pc;
    logic [63:0] m_q [$];
    logic        m_halt, m_err, m_known = 1'b0;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'hA5000000 | {8'h00, a[23:0]};
    endfunction

    assign imem_rdata  = imem(imem_addr);
    assign imem2_rdata = imem(imem2_addr);

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .misalign_err(misalign_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFF8)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_addr(imem2_addr), .imem_rdata(imem2_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .dec_valid(dec_valid2), .dec_ready(dec_ready2), .dec_instr(dec_instr2),
        .dec_pc(dec_pc2), .misalign_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a two-entry queue of {pc, instr}, advanced once per rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 32'h0;
            m_q.delete();
            m_halt = 1'b0;
            m_err = 1'b0;
            m_known = 1'b1;
        end else if (m_known && !m_halt) begin
            if (redirect_valid) begin
                m_q.delete();
                if (redirect_pc[1:0] != 2'b00) begin
                    m_halt = 1'b1;
                    m_err = 1'b1;
                end else m_pc = redirect_pc;
            end else begin
                if (m_q.size() > 0 && dec_ready) void'(m_q.pop_front());
                if (m_q.size() < 2) begin
                    m_q.push_back({m_pc, imem(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_dec_valid", {31'b0, dec_valid}, {31'b0, m_q.size() != 0});
            chk("m_misalign", {31'b0, misalign_err}, {31'b0, m_err});
            if (m_q.size() != 0) begin
                chk("m_dec_pc", dec_pc, m_q[0][63:32]);
                chk("m_dec_instr", dec_instr, m_q[0][31:0]);
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; dec_ready = 1'b0; dec_ready2 = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        edges(2);
        chk("rst_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);
        // 1: streaming from reset
        rst_n = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edges(1);
            chk("s1_valid", {31'b0, dec_valid}, 32'd1);
            chk("s1_pc", dec_pc, 32'(i * 4));
            chk("s1_instr", dec_instr, 32'hA5000000 + 32'(i * 4));
        end
        // 2: back-pressure fills the buffer and holds the PC
        rst_n = 1'b0; edges(1);
        rst_n = 1'b1; dec_ready = 1'b0; edges(5);
        chk("s2_addr_held", imem_addr, 32'h8);
        chk("s2_head", dec_pc, 32'h0);
        dec_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            edges(1);
            chk("s2_pc", dec_pc, 32'(i * 4));
        end
        // 3: aligned redirect while full
        dec_ready = 1'b0; edges(2);
        redirect_valid = 1'b1; redirect_pc = 32'h40; dec_ready = 1'b1; edges(1);
        chk("s3_bubble", {31'b0, dec_valid}, 32'd0);
        chk("s3_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0; edges(1);
        chk("s3_pc", dec_pc, 32'h40);
        chk("s3_instr", dec_instr, 32'hA5000040);
        // 4: misaligned redirect halts; later redirects ignored; reset clears
        redirect_valid = 1'b1; redirect_pc = 32'h42; edges(1);
        chk("s4_err", {31'b0, misalign_err}, 32'd1);
        chk("s4_valid", {31'b0, dec_valid}, 32'd0);
        chk("s4_addr", imem_addr, 32'h44);
        redirect_pc = 32'h80; edges(3);
        chk("s4_ignored", imem_addr, 32'h44);
        chk("s4_halt_valid", {31'b0, dec_valid}, 32'd0);
        redirect_valid = 1'b0; rst_n = 1'b0; edges(1);
        chk("s4_clr", {31'b0, misalign_err}, 32'd0);
        chk("s4_rst_addr", imem_addr, 32'h0);
        // 6: reset beats a concurrent redirect while full
        rst_n = 1'b1; dec_ready = 1'b0; edges(3);
        chk("s6_full_addr", imem_addr, 32'h8);
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; edges(1);
        chk("s6_valid", {31'b0, dec_valid}, 32'd0);
        chk("s6_addr", imem_addr, 32'h0);
        redirect_valid = 1'b0; rst_n = 1'b1; dec_ready = 1'b1; edges(2);
        // 5: PC wraps past 0xFFFFFFFC on the second instance
        rst2_n = 1'b1; dec_ready2 = 1'b1;
        edges(1);
        chk("s5_pc0", dec_pc2, 32'hFFFFFFF8);
        chk("s5_in0", dec_instr2, 32'hA5FFFFF8);
        edges(1);
        chk("s5_pc1", dec_pc2, 32'hFFFFFFFC);
        edges(1);
        chk("s5_pc2", dec_pc2, 32'h00000000);
        chk("s5_in2", dec_instr2, 32'hA5000000);
        chk("s5_valid", {31'b0, dec_valid2}, 32'd1);
        edges(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
